// File: rtl/monitor_pkt_arbiter.sv
// monitor_pkt_arbiter: round-robin packet scheduler merging NUM_INPUTS
// NetFPGA-style streams into one, switching inputs only at packet boundaries.
// Optional feature macro: MON_ARB_CPU_PRIO_EN (input 0 wins every idle arbitration).
module monitor_pkt_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_BITS   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_INPUTS-1:0]            in_wr,
  output logic [NUM_INPUTS-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [SEL_BITS-1:0]              arb_grant,
  output logic                             arb_active
);

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PTR_W    = 2;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned NF_LEVEL = 3;
  localparam int unsigned IDX_W    = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {IDLE, HDRS, PKT} state_t;

  logic [NUM_INPUTS-1:0] head_vld;
  logic [NUM_INPUTS-1:0] pop;
  logic [DATA_WIDTH-1:0] head_data [NUM_INPUTS];
  logic [CTRL_WIDTH-1:0] head_ctrl [NUM_INPUTS];

  state_t                state, state_nxt;
  logic [SEL_BITS-1:0]   g, g_nxt, last_g, last_g_nxt;
  logic                  pop_en;
  logic                  found;
  logic [IDX_W-1:0]      cand;
  logic [NUM_INPUTS-1:0] rr_req;
  logic                  head_vld_g;
  logic [DATA_WIDTH-1:0] head_data_g;
  logic [CTRL_WIDTH-1:0] head_ctrl_g;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_q
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CTRL_WIDTH-1:0] mem_c [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, cnt_nxt;
    logic                  fresh, rdy_q, wr_ok;

    assign wr_ok        = in_wr[i] && (count != CNT_W'(DEPTH));
    assign pop[i]       = pop_en && (g == SEL_BITS'(i));
    // A word written into an empty queue needs one cycle to reach the head.
    assign head_vld[i]  = (count != '0) && !fresh;
    assign head_data[i] = mem_d[rd_ptr];
    assign head_ctrl[i] = mem_c[rd_ptr];
    assign in_rdy[i]    = rdy_q;

    // Occupancy after this cycle's write and pop.
    always_comb begin
      cnt_nxt = count + CNT_W'(wr_ok) - CNT_W'(pop[i]);
    end

    // Queue storage; contents need no reset.
    always_ff @(posedge clk) begin
      if (wr_ok) begin
        mem_d[wr_ptr] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        mem_c[wr_ptr] <= in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end

    // Pointers, occupancy, head visibility and registered ready.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        fresh  <= 1'b0;
        rdy_q  <= 1'b0;
      end else begin
        if (wr_ok)  wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[i]) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= cnt_nxt;
        fresh <= wr_ok && (count == '0);
        rdy_q <= (cnt_nxt < CNT_W'(NF_LEVEL));
      end
    end
  end

  // Head of the granted queue.
  always_comb begin
    head_vld_g  = 1'b0;
    head_data_g = '0;
    head_ctrl_g = '0;
    for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
      if (g == SEL_BITS'(j)) begin
        head_vld_g  = head_vld[IDX_W'(j)];
        head_data_g = head_data[IDX_W'(j)];
        head_ctrl_g = head_ctrl[IDX_W'(j)];
      end
    end
  end

  // Next-state, grant selection and pop decision.
  always_comb begin
    state_nxt  = state;
    g_nxt      = g;
    last_g_nxt = last_g;
    pop_en     = 1'b0;
    found      = 1'b0;
    cand       = '0;
    rr_req     = head_vld;
    case (state)
      IDLE: begin
`ifdef MON_ARB_CPU_PRIO_EN
        rr_req[0] = 1'b0;
        if (head_vld[0]) begin
          found = 1'b1;
          g_nxt = '0;
        end
`endif
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
          cand = IDX_W'((32'(last_g) + k) % NUM_INPUTS);
          if (!found && rr_req[cand]) begin
            found      = 1'b1;
            g_nxt      = SEL_BITS'(cand);
            last_g_nxt = SEL_BITS'(cand);
          end
        end
        if (found) state_nxt = HDRS;
      end
      HDRS: begin
        if (out_rdy && head_vld_g) begin
          pop_en = 1'b1;
          if (head_ctrl_g == '0) state_nxt = PKT;
        end
      end
      PKT: begin
        if (out_rdy && head_vld_g) begin
          pop_en = 1'b1;
          if (head_ctrl_g != '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      g          <= '0;
      last_g     <= SEL_BITS'(NUM_INPUTS - 1);
      arb_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      g          <= g_nxt;
      last_g     <= last_g_nxt;
      arb_active <= (state_nxt != IDLE);
    end
  end

  assign arb_grant = g;

  // Registered merged output; data holds when nothing is popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= pop_en;
      if (pop_en) begin
        out_data <= head_data_g;
        out_ctrl <= head_ctrl_g;
      end
    end
  end

endmodule

// File: tb/tb_monitor_pkt_arbiter.sv
// Scoreboard bench for monitor_pkt_arbiter: expected words are queued in the
// order the arbiter must emit them and compared as out_wr words appear.
module tb_monitor_pkt_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NI = 4;
  localparam int unsigned SB = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI*DW-1:0] in_data;
  logic [NI*CW-1:0] in_ctrl;
  logic [NI-1:0]    in_wr;
  logic [NI-1:0]    in_rdy;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy;
  logic [SB-1:0]    arb_grant;
  logic             arb_active;

  logic [DW-1:0] tb_data [NI];
  logic [CW-1:0] tb_ctrl [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_pack
    assign in_data[gi*DW +: DW] = tb_data[gi];
    assign in_ctrl[gi*CW +: CW] = tb_ctrl[gi];
  end

  monitor_pkt_arbiter #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(NI), .SEL_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .arb_grant(arb_grant), .arb_active(arb_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic [SB-1:0] grant;
    int            gap;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle_cnt = 0;
  int   last_wr_cycle = 0;
  int   ref_cycle = 0;
  int   out_count = 0;
  bit   abort = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdata(input int i, input int w, input int tag);
    return (64'(tag) << 32) | (64'(i) << 16) | 64'(w);
  endfunction

  function automatic logic [CW-1:0] wctrl(input int w, input int n);
    if (w == 0) return 8'hFF;
    if (w == n - 1) return 8'h01;
    return 8'h00;
  endfunction

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Output monitor: pop and compare one expected word per out_wr.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && out_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_wr", 64'(out_wr), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        check("arb_grant", 64'(arb_grant), 64'(e.grant));
        if (e.gap >= 0) check("word_gap", 64'(cycle_cnt - last_wr_cycle), 64'(e.gap));
        if (e.lat >= 0) check("latency", 64'(cycle_cnt - ref_cycle), 64'(e.lat));
      end
      last_wr_cycle = cycle_cnt;
      out_count++;
    end
  end

  task automatic push_pkt(input int i, input int n, input int tag,
                          input int gap_first, input int gap_rest, input int lat_first);
    exp_t e;
    for (int w = 0; w < n; w++) begin
      e.data  = wdata(i, w, tag);
      e.ctrl  = wctrl(w, n);
      e.grant = SB'(i);
      e.gap   = (w == 0) ? gap_first : gap_rest;
      e.lat   = (w == 0) ? lat_first : -1;
      exp_q.push_back(e);
    end
  endtask

  // Drive one word on input i, honouring in_rdy; called and returns at a negedge.
  task automatic drive_word(input int i, input int w, input int n, input int tag);
    logic [1:0] ix;
    int guard;
    ix = 2'(i);
    guard = 0;
    in_wr[ix] = 1'b0;
    while (in_rdy[ix] !== 1'b1 && !abort && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (abort) return;
    if (guard >= 300) begin
      check("in_rdy_wait", 64'(in_rdy[ix]), 64'(1));
      return;
    end
    if (w == 0) ref_cycle = cycle_cnt + 1;
    tb_data[ix] = wdata(i, w, tag);
    tb_ctrl[ix] = wctrl(w, n);
    in_wr[ix]   = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_pkt(input int i, input int n, input int tag);
    for (int w = 0; w < n; w++) begin
      if (abort) break;
      drive_word(i, w, n, tag);
    end
    in_wr[2'(i)] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
    check({tag, "_idle"}, 64'(arb_active), 64'(0));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    reset   = 1'b0;
    in_wr   = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < int'(NI); i++) begin
      tb_data[i] = '0;
      tb_ctrl[i] = '0;
    end

    // Reset values
    #12;
    check("rst_out_wr", 64'(out_wr), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_grant", 64'(arb_grant), 64'(0));
    check("rst_active", 64'(arb_active), 64'(0));
    check("rst_in_rdy", 64'(in_rdy), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", 64'(in_rdy), 64'hF);

    // All four inputs at once: order 0,1,2,3 with one idle cycle between packets
    push_pkt(0, 4, 2, -1, 1, -1);
    push_pkt(1, 4, 2, 2, 1, -1);
    push_pkt(2, 4, 2, 2, 1, -1);
    push_pkt(3, 4, 2, 2, 1, -1);
    fork
      send_pkt(0, 4, 2);
      send_pkt(1, 4, 2);
      send_pkt(2, 4, 2);
      send_pkt(3, 4, 2);
    join
    wait_drain("t2_drain");

    // Back-to-back packets on input 0 with input 3 pending
`ifdef MON_ARB_CPU_PRIO_EN
    push_pkt(0, 3, 4, -1, 1, -1);
    push_pkt(0, 3, 6, -1, -1, -1);
    push_pkt(3, 3, 5, -1, -1, -1);
`else
    push_pkt(0, 3, 4, -1, 1, -1);
    push_pkt(3, 3, 5, -1, -1, -1);
    push_pkt(0, 3, 6, -1, -1, -1);
`endif
    fork
      begin
        send_pkt(0, 3, 4);
        send_pkt(0, 3, 6);
      end
      send_pkt(3, 3, 5);
    join
    wait_drain("t4_drain");

    // Single 3-word packet on input 2: latency 3, consecutive words
    push_pkt(2, 3, 1, -1, 1, 3);
    send_pkt(2, 3, 1);
    wait_drain("t1_drain");
    check("t1_grant_held", 64'(arb_grant), 64'(2));

    // Stall out_rdy for 5 cycles mid-packet on input 1
    push_pkt(1, 8, 7, -1, -1, -1);
    base = out_count;
    fork
      send_pkt(1, 8, 7);
      begin
        guard = 0;
        while (out_count < base + 3 && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        check("t3_reached_pkt", 64'(out_count - base), 64'(3));
        out_rdy = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
          check("t3_stall_out_wr", 64'(out_wr), 64'(0));
        end
        @(negedge clk);
        check("t3_in_rdy1", 64'(in_rdy[1]), 64'(0));
        check("t3_grant", 64'(arb_grant), 64'(1));
        check("t3_active", 64'(arb_active), 64'(1));
        out_rdy = 1'b1;
      end
    join
    wait_drain("t3_drain");

    // Simultaneous write and pop on a queue holding 3 words
    push_pkt(0, 5, 8, -1, -1, -1);
    out_rdy = 1'b0;
    drive_word(0, 0, 5, 8);
    drive_word(0, 1, 5, 8);
    drive_word(0, 2, 5, 8);
    in_wr[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_rdy_full", 64'(in_rdy[0]), 64'(0));
    check("t6_active", 64'(arb_active), 64'(1));
    tb_data[0] = wdata(0, 3, 8);
    tb_ctrl[0] = wctrl(3, 5);
    in_wr[0]   = 1'b1;
    out_rdy    = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rdy_after", 64'(in_rdy[0]), 64'(0));
    check("t6_popped", 64'(out_wr), 64'(1));
    @(negedge clk);
    in_wr[0] = 1'b0;
    drive_word(0, 4, 5, 8);
    in_wr[0] = 1'b0;
    wait_drain("t6_drain");

    // Asynchronous reset after 2 of 6 words, then a clean packet on input 1
    push_pkt(3, 6, 9, -1, -1, -1);
    base = out_count;
    fork
      send_pkt(3, 6, 9);
      begin
        guard = 0;
        while (out_count < base + 2 && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        #1;
        reset = 1'b0;
        abort = 1'b1;
        #1;
        check("t5_out_wr", 64'(out_wr), 64'(0));
        check("t5_active", 64'(arb_active), 64'(0));
        check("t5_in_rdy", 64'(in_rdy), 64'(0));
        check("t5_grant", 64'(arb_grant), 64'(0));
      end
    join
    check("t5_partial", 64'(exp_q.size()), 64'(4));
    exp_q.delete();
    in_wr = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_pkt(1, 4, 10, -1, 1, 3);
    send_pkt(1, 4, 10);
    wait_drain("t5_drain");
    repeat (5) @(negedge clk);
    check("t5_no_residual", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_pkt_arbiter.md
Name: monitor_pkt_arbiter

Overview:
- Round-robin packet scheduler. Merges NUM_INPUTS NetFPGA-style packet streams into the single stream that feeds the monitor NIC's output port lookup.
- Each input has a small show-ahead queue. The block switches inputs only at packet boundaries, so packets are never interleaved.
- Packet format: module-header words (ctrl!=0), then data words (ctrl==0), then the last word (ctrl!=0, EOP).
- Uses the standard in_wr/in_rdy and out_wr/out_rdy handshake.

Parameters:
- DATA_WIDTH, 64, datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- NUM_INPUTS, 4, number of input streams (2..8).
- SEL_BITS, 2, grant index width; must be >= ceil(log2(NUM_INPUTS)).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  NUM_INPUTS*DATA_WIDTH  flattened data; input i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_INPUTS*CTRL_WIDTH  flattened ctrl, same packing as in_data.
- in_wr  in  NUM_INPUTS  per-input word write strobe.
- in_rdy  out  NUM_INPUTS  per-input ready; equals !nearly_full of that input's queue.
- out_data  out  DATA_WIDTH  merged data (registered).
- out_ctrl  out  CTRL_WIDTH  merged ctrl (registered).
- out_wr  out  1  merged write strobe (registered).
- out_rdy  in  1  downstream ready.
- arb_grant  out  SEL_BITS  index of the input currently or last granted.
- arb_active  out  1  high while a packet transfer is in progress.

Behaviour:
- Reset values while reset==0: out_wr=0, out_data=0, out_ctrl=0, arb_grant=0, arb_active=0, state=IDLE, all queues empty, in_rdy all 0.
- Reset is asynchronous on assertion. Deassertion takes effect at the next clk edge.
- Reset mid-packet discards queued words and the partial packet. No further out_wr occurs for that packet.
- Queues:
  - One first-word-fall-through queue per input, 4 entries deep.
  - Head word is visible while non-empty. A pop removes it.
  - nearly_full = occupancy >= 3.
  - in_wr while a queue is full is a protocol violation; the word is dropped and queue contents are unchanged.
  - A write and a pop in the same cycle are both honoured.
- State machine (registered; grant register is g):
  - IDLE: no pop. If any queue is non-empty, set g to the first non-empty queue searching (last_g+1) mod NUM_INPUTS upward, wrapping. Go to HDRS and set arb_active=1 at the next edge. Otherwise stay in IDLE.
  - HDRS: pop when out_rdy && queue[g] non-empty. If the popped head has ctrl==0, go to PKT.
  - PKT: pop when out_rdy && queue[g] non-empty. If the popped head has ctrl!=0 (EOP), go to IDLE and set arb_active=0.
  - A stalled or empty granted queue holds the grant. Other inputs are never served mid-packet.
- Output:
  - On a pop: out_data/out_ctrl <= head word and out_wr <= 1 at the next edge.
  - With no pop: out_wr <= 0; out_data/out_ctrl hold their last value.
  - Words are never read while out_rdy==0.
- Latency, from in_wr at edge N into an idle block with empty queues:
  - Grant registered at N+2.
  - First pop in cycle N+2.
  - out_wr=1 after edge N+3.
- Throughput: one idle arbitration cycle between consecutive packets. Otherwise one word per cycle.
- Round-robin state: last_g updates to g on each transition to HDRS. Reset value of last_g is NUM_INPUTS-1, so input 0 wins first.

Optional Feature:
- Macro: MON_ARB_CPU_PRIO_EN.
- Defined: in IDLE, input 0 (CPU DMA path) is granted whenever its queue is non-empty, regardless of round-robin position. Other inputs use round-robin among themselves. last_g is not updated on an input-0 grant.
- Undefined: pure round-robin across all inputs as described above.

Test Plan:
- Single 3-word packet on input 2 (ctrl 0xFF, 0x00, 0x01), out_rdy=1 -> out_wr high 3 consecutive cycles starting 3 cycles after the first in_wr; words and order identical; arb_grant=2.
- Inputs 0..3 each hold one 4-word packet at the same time -> output order 0,1,2,3; one idle cycle between packets; no interleaving.
- out_rdy low for 5 cycles mid-PKT on input 1 -> no out_wr during the stall; in_rdy[1]=0 once 3 words are queued; packet resumes intact with the grant held.
- Back-to-back packets on input 0 with input 3 also pending -> grant alternates 0,3,0; the second input-0 packet waits. With MON_ARB_CPU_PRIO_EN defined -> order 0,0,3.
- Reset (0) asserted asynchronously in PKT after 2 of 6 words -> out_wr=0 immediately; after release the next packet on input 1 is forwarded cleanly with no residual words.
- Simultaneous in_wr and pop on a queue holding 3 words -> occupancy stays 3; in_rdy stays 0; no word is lost or duplicated.
